pc_monitor: RTL and testbench
=============================

Name: pc_monitor

Overview:
Sequential PC-stream checker for the single-cycle/pipelined CPU fetch stage, successor to the combinational PC range/alignment check. Each valid fetch PC is checked for range, alignment and sequential flow (PC must equal previous PC + 4 unless a jump/branch is flagged). Faults are registered, classified, counted, and the first faulting PC is trapped until software/bench clears it.

Parameters:
BASE, 32'h0000_3000, lowest legal PC (inclusive)
LIMIT, 32'h0000_4fff, highest legal byte address (inclusive)
ALIGN_BITS, 2, number of low PC bits that must be zero (0..4)
STEP, 4, expected increment for sequential fetch
CNT_W, 8, width of fault counter

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous active-high reset
pc_valid  input  1  pc carries a fetch this cycle
pc  input  32  fetch address
redirect  input  1  this pc is a jump/branch target; flow check waived
clr  input  1  clear trap state and fault counter
fault  output  1  one-cycle pulse, registered, for a faulting fetch
fault_code  output  3  bit0 range, bit1 align, bit2 flow; valid with fault
trapped  output  1  sticky: at least one fault since reset/clr
first_bad_pc  output  32  pc of first fault since reset/clr
first_code  output  3  fault_code of that first fault
fault_cnt  output  CNT_W  saturating count of faulting fetches

Behaviour:
- Reset (async, active-high): fault=0, fault_code=0, trapped=0, first_bad_pc=0, first_code=0, fault_cnt=0, prev_pc=0, state=IDLE.
- States: IDLE (no reference PC yet), RUN (prev_pc valid), TRAP (RUN plus sticky first fault captured).
- Transitions: IDLE->RUN on first pc_valid with no fault; IDLE/RUN->TRAP on any faulting valid fetch; TRAP->IDLE on clr; RUN->IDLE on clr. No other transitions.
- Checks on pc_valid, evaluated combinationally and registered (latency 1 cycle: fault visible the cycle after the fetch):
  - range: pc < BASE or pc > LIMIT (unsigned 32-bit compare).
  - align: pc[ALIGN_BITS-1:0] != 0; ALIGN_BITS=0 disables.
  - flow: state != IDLE and redirect=0 and pc != prev_pc + STEP (32-bit wrap-around add, no carry out). Never raised in IDLE.
  - Multiple bits may be set simultaneously.
- prev_pc updated to pc on every pc_valid, faulting or not, so flow checking resumes relative to the latest fetch.
- pc_valid=0: no checks, fault=0 next cycle, prev_pc held.
- fault_cnt increments by 1 per faulting fetch, saturates at all-ones.
- first_bad_pc/first_code loaded only on transition into TRAP; subsequent faults do not overwrite.
- clr has priority over a same-cycle fault: state->IDLE, trapped/first_*/fault_cnt cleared, prev_pc cleared; the concurrent fetch is not checked and fault=0 next cycle.
- Reset asserted mid-operation clears everything immediately regardless of clk.

Test Plan:
- Reset then pc_valid with 0x3000,0x3004,0x3008 (redirect=0) -> fault never asserts, trapped=0, fault_cnt=0.
- pc=0x2ffc valid in IDLE -> next cycle fault=1, fault_code=3'b001, trapped=1, first_bad_pc=0x2ffc, fault_cnt=1; pc=0x5000 afterwards -> fault_code=001, fault_cnt=2, first_bad_pc unchanged.
- Sequence 0x3000 then 0x3006 -> fault_code=3'b110 (align+flow); then 0x300a -> no flow fault (prev updated), align fault code=010.
- 0x3000 then 0x4000 with redirect=1 -> no fault; same without redirect -> fault_code=100.
- Force 256 faults with CNT_W=8 -> fault_cnt stays 8'hff; assert clr together with a bad pc -> next cycle fault=0, trapped=0, fault_cnt=0, first_bad_pc=0.
- Assert reset asynchronously between clock edges while trapped -> all outputs zero before next edge; first fetch after release not flow-checked.

Source files
------------

// File: rtl/pc_monitor.sv
// pc_monitor: checks the fetch PC stream for range, alignment and sequential flow.
// Faults are registered one cycle after the fetch. They are classified,
// counted with saturation, and the first faulting PC is latched until clr.
module pc_monitor #(
    parameter logic [31:0] BASE       = 32'h0000_3000,
    parameter logic [31:0] LIMIT      = 32'h0000_4fff,
    parameter int          ALIGN_BITS = 2,
    parameter logic [31:0] STEP       = 32'd4,
    parameter int          CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_valid,
    input  logic [31:0]      pc,
    input  logic             redirect,
    input  logic             clr,
    output logic             fault,
    output logic [2:0]       fault_code,
    output logic             trapped,
    output logic [31:0]      first_bad_pc,
    output logic [2:0]       first_code,
    output logic [CNT_W-1:0] fault_cnt
);

    // The low ALIGN_BITS must be zero. A mask of all zeros (ALIGN_BITS=0)
    // disables the check without a zero-width slice.
    localparam logic [31:0] ALIGN_MASK = (32'd1 << ALIGN_BITS) - 32'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      prev_pc_q, prev_pc_d;
    logic             fault_q, fault_d;
    logic [2:0]       fault_code_q, fault_code_d;
    logic [31:0]      first_bad_pc_q, first_bad_pc_d;
    logic [2:0]       first_code_q, first_code_d;
    logic [CNT_W-1:0] fault_cnt_q, fault_cnt_d;

    logic             range_err;
    logic             align_err;
    logic             flow_err;
    logic [2:0]       code_now;
    logic             any_err;
    logic [31:0]      expected_pc;

    // Classify the current fetch. A pending clr means the fetch is ignored.
    always_comb begin
        expected_pc = prev_pc_q + STEP;
        range_err   = (pc < BASE) || (pc > LIMIT);
        align_err   = |(pc & ALIGN_MASK);
        flow_err    = (state_q != IDLE) && !redirect && (pc != expected_pc);
        code_now    = 3'b000;
        if (pc_valid && !clr) begin
            code_now = {flow_err, align_err, range_err};
        end
        any_err = |code_now;
    end

    // Next-state and datapath updates. clr has priority over a same-cycle fault.
    always_comb begin
        state_d        = state_q;
        prev_pc_d      = prev_pc_q;
        fault_d        = 1'b0;
        fault_code_d   = 3'b000;
        first_bad_pc_d = first_bad_pc_q;
        first_code_d   = first_code_q;
        fault_cnt_d    = fault_cnt_q;

        if (clr) begin
            state_d        = IDLE;
            prev_pc_d      = 32'd0;
            first_bad_pc_d = 32'd0;
            first_code_d   = 3'b000;
            fault_cnt_d    = '0;
        end else if (pc_valid) begin
            // The latest fetch is always the flow reference, good or bad.
            prev_pc_d    = pc;
            fault_d      = any_err;
            fault_code_d = code_now;
            if (any_err) begin
                if (state_q != TRAP) begin
                    first_bad_pc_d = pc;
                    first_code_d   = code_now;
                end
                state_d = TRAP;
                if (fault_cnt_q != {CNT_W{1'b1}}) begin
                    fault_cnt_d = fault_cnt_q + 1'b1;
                end
            end else if (state_q == IDLE) begin
                state_d = RUN;
            end
        end
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            prev_pc_q      <= 32'd0;
            fault_q        <= 1'b0;
            fault_code_q   <= 3'b000;
            first_bad_pc_q <= 32'd0;
            first_code_q   <= 3'b000;
            fault_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            prev_pc_q      <= prev_pc_d;
            fault_q        <= fault_d;
            fault_code_q   <= fault_code_d;
            first_bad_pc_q <= first_bad_pc_d;
            first_code_q   <= first_code_d;
            fault_cnt_q    <= fault_cnt_d;
        end
    end

    assign fault        = fault_q;
    assign fault_code   = fault_code_q;
    assign trapped      = (state_q == TRAP);
    assign first_bad_pc = first_bad_pc_q;
    assign first_code   = first_code_q;
    assign fault_cnt    = fault_cnt_q;

endmodule

// File: tb/tb_pc_monitor.sv
// Directed testbench for pc_monitor with hand-computed expectations.
module tb_pc_monitor;

    logic        clk;
    logic        reset;
    logic        pc_valid;
    logic [31:0] pc;
    logic        redirect;
    logic        clr;
    logic        fault;
    logic [2:0]  fault_code;
    logic        trapped;
    logic [31:0] first_bad_pc;
    logic [2:0]  first_code;
    logic [7:0]  fault_cnt;

    int checks = 0;
    int errors = 0;

    pc_monitor dut (
        .clk          (clk),
        .reset        (reset),
        .pc_valid     (pc_valid),
        .pc           (pc),
        .redirect     (redirect),
        .clr          (clr),
        .fault        (fault),
        .fault_code   (fault_code),
        .trapped      (trapped),
        .first_bad_pc (first_bad_pc),
        .first_code   (first_code),
        .fault_cnt    (fault_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one fetch for one cycle; outputs are sampled 1 time unit after the edge.
    task automatic fetch(input logic [31:0] p, input logic rd, input logic c);
        pc_valid = 1'b1;
        pc       = p;
        redirect = rd;
        clr      = c;
        @(posedge clk);
        #1;
        pc_valid = 1'b0;
        redirect = 1'b0;
        clr      = 1'b0;
        $display("fetch pc=%h redirect=%0b clr=%0b -> fault=%0b code=%b trapped=%0b first=%h cnt=%0d",
                 p, rd, c, fault, fault_code, trapped, first_bad_pc, fault_cnt);
    endtask

    task automatic idle_cycle();
        pc_valid = 1'b0;
        @(posedge clk);
        #1;
        $display("idle -> fault=%0b code=%b trapped=%0b cnt=%0d", fault, fault_code, trapped, fault_cnt);
    endtask

    task automatic chk_all(input string tag, input logic f, input logic [2:0] code,
                           input logic t, input logic [31:0] fpc, input logic [2:0] fcode,
                           input logic [7:0] cnt);
        chk({tag, ".fault"},      {31'd0, fault},      {31'd0, f});
        chk({tag, ".code"},       {29'd0, fault_code}, {29'd0, code});
        chk({tag, ".trapped"},    {31'd0, trapped},    {31'd0, t});
        chk({tag, ".first_pc"},   first_bad_pc,        fpc);
        chk({tag, ".first_code"}, {29'd0, first_code}, {29'd0, fcode});
        chk({tag, ".cnt"},        {24'd0, fault_cnt},  {24'd0, cnt});
    endtask

    initial begin
        reset    = 1'b1;
        pc_valid = 1'b0;
        pc       = 32'd0;
        redirect = 1'b0;
        clr      = 1'b0;
        @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 3'b000, 1'b0, 32'd0, 3'b000, 8'd0);
        reset = 1'b0;

        // Clean sequential stream
        fetch(32'h3000, 1'b0, 1'b0); chk_all("seq0", 1'b0, 3'b000, 1'b0, 32'd0, 3'b000, 8'd0);
        fetch(32'h3004, 1'b0, 1'b0); chk_all("seq1", 1'b0, 3'b000, 1'b0, 32'd0, 3'b000, 8'd0);
        fetch(32'h3008, 1'b0, 1'b0); chk_all("seq2", 1'b0, 3'b000, 1'b0, 32'd0, 3'b000, 8'd0);

        // Return to IDLE, then a below-BASE fetch: range only (no flow in IDLE)
        fetch(32'h0, 1'b0, 1'b1);     chk_all("clr0", 1'b0, 3'b000, 1'b0, 32'd0, 3'b000, 8'd0);
        fetch(32'h2ffc, 1'b0, 1'b0);  chk_all("below", 1'b1, 3'b001, 1'b1, 32'h2ffc, 3'b001, 8'd1);
        fetch(32'h5000, 1'b1, 1'b0);  chk_all("above", 1'b1, 3'b001, 1'b1, 32'h2ffc, 3'b001, 8'd2);
        idle_cycle();                 chk_all("idle0", 1'b0, 3'b000, 1'b1, 32'h2ffc, 3'b001, 8'd2);

        // Align + flow, then flow resumes from the faulting pc
        fetch(32'h0, 1'b0, 1'b1);     chk_all("clr1", 1'b0, 3'b000, 1'b0, 32'd0, 3'b000, 8'd0);
        fetch(32'h3000, 1'b0, 1'b0);  chk_all("al0", 1'b0, 3'b000, 1'b0, 32'd0, 3'b000, 8'd0);
        fetch(32'h3006, 1'b0, 1'b0);  chk_all("al1", 1'b1, 3'b110, 1'b1, 32'h3006, 3'b110, 8'd1);
        fetch(32'h300a, 1'b0, 1'b0);  chk_all("al2", 1'b1, 3'b010, 1'b1, 32'h3006, 3'b110, 8'd2);

        // Redirect waives flow; without it a jump is a flow fault
        fetch(32'h0, 1'b0, 1'b1);     chk_all("clr2", 1'b0, 3'b000, 1'b0, 32'd0, 3'b000, 8'd0);
        fetch(32'h3000, 1'b0, 1'b0);  chk_all("rd0", 1'b0, 3'b000, 1'b0, 32'd0, 3'b000, 8'd0);
        fetch(32'h4000, 1'b1, 1'b0);  chk_all("rd1", 1'b0, 3'b000, 1'b0, 32'd0, 3'b000, 8'd0);
        fetch(32'h3000, 1'b0, 1'b0);  chk_all("rd2", 1'b1, 3'b100, 1'b1, 32'h3000, 3'b100, 8'd1);
        // Idle cycle holds prev_pc, so 0x3004 is in sequence
        idle_cycle();                 chk_all("idle1", 1'b0, 3'b000, 1'b1, 32'h3000, 3'b100, 8'd1);
        fetch(32'h3004, 1'b0, 1'b0);  chk_all("hold", 1'b0, 3'b000, 1'b1, 32'h3000, 3'b100, 8'd1);

        // LIMIT boundary: 0x4ffc legal, sequential 0x5000 is range only
        fetch(32'h0, 1'b0, 1'b1);     chk_all("clr3", 1'b0, 3'b000, 1'b0, 32'd0, 3'b000, 8'd0);
        fetch(32'h4ffc, 1'b0, 1'b0);  chk_all("lim0", 1'b0, 3'b000, 1'b0, 32'd0, 3'b000, 8'd0);
        fetch(32'h5000, 1'b0, 1'b0);  chk_all("lim1", 1'b1, 3'b001, 1'b1, 32'h5000, 3'b001, 8'd1);

        // Saturation: 260 more range faults from count 1
        for (int i = 0; i < 260; i++) begin
            fetch(32'h2ffc, 1'b1, 1'b0);
        end
        chk_all("sat", 1'b1, 3'b001, 1'b1, 32'h5000, 3'b001, 8'hff);

        // clr beats a same-cycle bad fetch
        fetch(32'h2ffc, 1'b0, 1'b1);  chk_all("clrbad", 1'b0, 3'b000, 1'b0, 32'd0, 3'b000, 8'd0);

        // Async reset while trapped
        fetch(32'h2ffc, 1'b0, 1'b0);  chk_all("pre_rst", 1'b1, 3'b001, 1'b1, 32'h2ffc, 3'b001, 8'd1);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 3'b000, 1'b0, 32'd0, 3'b000, 8'd0);
        #1;
        reset = 1'b0;
        $display("async reset pulse applied between edges");
        // prev_pc is 0 and state IDLE: no flow check on first fetch
        fetch(32'h3008, 1'b0, 1'b0);  chk_all("post0", 1'b0, 3'b000, 1'b0, 32'd0, 3'b000, 8'd0);
        fetch(32'h300c, 1'b0, 1'b0);  chk_all("post1", 1'b0, 3'b000, 1'b0, 32'd0, 3'b000, 8'd0);
        fetch(32'h3000, 1'b0, 1'b0);  chk_all("post2", 1'b1, 3'b100, 1'b1, 32'h3000, 3'b100, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
